// File: rtl/i2c_register_reader.sv
// I2C master that reads one 16-bit register from a 7-bit-addressed slave.
// The bus is timed by a quarter-bit divider. Every bit slot has four quarters:
// Q0 SCL low and SDA set, Q1 SCL released, Q2 SDA sampled, Q3 SCL pulled low.
// The pad enables are registered so the open-drain pins never glitch.
module i2c_register_reader #(
  parameter int          INPUT_CLOCK_SPEED = 50000000,
  parameter int          I2C_SPEED         = 100000,
  parameter logic [6:0]  DEVICE_ADDRESS    = 7'h48,
  parameter logic [7:0]  REGISTER_ADDRESS  = 8'h00
) (
  input  logic        inputClock,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        dataValid,
  output logic [15:0] readValue,
  output logic        ackError,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        scl_oe
);

  localparam int QDIV = INPUT_CLOCK_SPEED / (4 * I2C_SPEED);
  localparam int DIVW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(QDIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK1, REG, ACK2, RSTART, ADDR_R,
    ACK3, RD_MSB, MACK, RD_LSB, MNACK, STOP
  } stateT;

  stateT           state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bitCnt_q, bitCnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      msb_q, msb_d;
  logic [15:0]     readValue_q, readValue_d;
  logic            busy_q, busy_d;
  logic            dataValid_q, dataValid_d;
  logic            ackError_q, ackError_d;
  logic            readGood_q, readGood_d;
  logic            sdaSync1_q, sdaSync2_q;
  logic            sdaOe_q, sclOe_q;
  logic            sdaLow, sclLow;
  logic            quarterTick;

  assign quarterTick = (div_q == DIV_LAST);

  // Two-flop synchroniser on the SDA pad; resets to the idle (high) bus level
  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      sdaSync1_q <= 1'b1;
      sdaSync2_q <= 1'b1;
    end else begin
      sdaSync1_q <= sda_in;
      sdaSync2_q <= sdaSync1_q;
    end
  end

  // Main state, divider, counters and result registers
  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      qtr_q       <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      msb_q       <= '0;
      readValue_q <= '0;
      busy_q      <= 1'b0;
      dataValid_q <= 1'b0;
      ackError_q  <= 1'b0;
      readGood_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      qtr_q       <= qtr_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      msb_q       <= msb_d;
      readValue_q <= readValue_d;
      busy_q      <= busy_d;
      dataValid_q <= dataValid_d;
      ackError_q  <= ackError_d;
      readGood_q  <= readGood_d;
    end
  end

  // Next-state logic: quarter sequencing, sampling at the end of Q2, slot transitions at the end of Q3
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    qtr_d       = qtr_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    msb_d       = msb_q;
    readValue_d = readValue_q;
    busy_d      = busy_q;
    dataValid_d = 1'b0;
    ackError_d  = ackError_q;
    readGood_d  = readGood_q;

    if (state_q == IDLE) begin
      if (start) begin
        state_d    = START;
        div_d      = '0;
        qtr_d      = '0;
        bitCnt_d   = '0;
        busy_d     = 1'b1;
        ackError_d = 1'b0;
        readGood_d = 1'b0;
      end
    end else begin
      div_d = quarterTick ? '0 : div_q + DIVW'(1);
      if (quarterTick) begin
        if (qtr_q != 2'd3) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd2) begin
            case (state_q)
              ACK1, ACK2, ACK3: if (sdaSync2_q) ackError_d = 1'b1;
              RD_MSB, RD_LSB:   shift_d = {shift_q[6:0], sdaSync2_q};
              default: ;
            endcase
          end
        end else begin
          qtr_d = 2'd0;
          case (state_q)
            START: begin
              state_d  = ADDR_W;
              shift_d  = {DEVICE_ADDRESS, 1'b0};
              bitCnt_d = '0;
            end
            ADDR_W, REG, ADDR_R: begin
              if (bitCnt_q == 3'd7) begin
                bitCnt_d = '0;
                case (state_q)
                  ADDR_W:  state_d = ACK1;
                  REG:     state_d = ACK2;
                  default: state_d = ACK3;
                endcase
              end else begin
                bitCnt_d = bitCnt_q + 3'd1;
                shift_d  = {shift_q[6:0], 1'b0};
              end
            end
            ACK1: begin
              state_d = ackError_q ? STOP : REG;
              shift_d = REGISTER_ADDRESS;
            end
            ACK2: state_d = ackError_q ? STOP : RSTART;
            RSTART: begin
              state_d  = ADDR_R;
              shift_d  = {DEVICE_ADDRESS, 1'b1};
              bitCnt_d = '0;
            end
            ACK3: begin
              state_d  = ackError_q ? STOP : RD_MSB;
              bitCnt_d = '0;
            end
            RD_MSB: begin
              if (bitCnt_q == 3'd7) begin
                state_d  = MACK;
                msb_d    = shift_q;
                bitCnt_d = '0;
              end else begin
                bitCnt_d = bitCnt_q + 3'd1;
              end
            end
            MACK: state_d = RD_LSB;
            RD_LSB: begin
              if (bitCnt_q == 3'd7) begin
                state_d  = MNACK;
                bitCnt_d = '0;
              end else begin
                bitCnt_d = bitCnt_q + 3'd1;
              end
            end
            MNACK: begin
              state_d    = STOP;
              readGood_d = 1'b1;
            end
            STOP: begin
              state_d = IDLE;
              busy_d  = 1'b0;
              if (readGood_q) begin
                readValue_d = {msb_q, shift_q};
                dataValid_d = 1'b1;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
    end
  end

  // Bus levels wanted in the current quarter; START/RSTART drop SDA in Q2 and STOP raises it in Q2 while SCL is released
  always_comb begin
    sclLow = 1'b0;
    sdaLow = 1'b0;
    case (state_q)
      START: begin
        sclLow = (qtr_q == 2'd3);
        sdaLow = (qtr_q >= 2'd2);
      end
      RSTART: begin
        sclLow = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sdaLow = (qtr_q >= 2'd2);
      end
      STOP: begin
        sclLow = (qtr_q == 2'd0);
        sdaLow = (qtr_q <= 2'd1);
      end
      ADDR_W, REG, ADDR_R: begin
        sclLow = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sdaLow = ~shift_q[7];
      end
      MACK: begin
        sclLow = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sdaLow = 1'b1;
      end
      ACK1, ACK2, ACK3, RD_MSB, RD_LSB, MNACK: begin
        sclLow = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sdaLow = 1'b0;
      end
      default: begin
        sclLow = 1'b0;
        sdaLow = 1'b0;
      end
    endcase
  end

  // Registered open-drain enables so the pads only change on clock edges
  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      sdaOe_q <= 1'b0;
      sclOe_q <= 1'b0;
    end else begin
      sdaOe_q <= sdaLow;
      sclOe_q <= sclLow;
    end
  end

  assign busy      = busy_q;
  assign dataValid = dataValid_q;
  assign readValue = readValue_q;
  assign ackError  = ackError_q;
  assign sda_oe    = sdaOe_q;
  assign scl_oe    = sclOe_q;

endmodule

// File: tb/tb_i2c_register_reader.sv
// Bench for i2c_register_reader: open-drain bus with a behavioural slave at 0x48,
// a transaction-level model of the master's outputs and bus traffic, and one
// compare process that checks the DUT against that model every cycle.
module tb_i2c_register_reader;

  localparam int CLK_HZ      = 400;
  localparam int SCL_HZ      = 10;
  localparam int QDIV        = CLK_HZ / (4 * SCL_HZ);
  localparam int SLOT        = 4 * QDIV;
  // START + five 9-clock bytes + RSTART + STOP
  localparam int GOOD_CYCLES = 48 * SLOT;
  // START + address byte with its ack clock + STOP
  localparam int NACK_CYCLES = 11 * SLOT;
  localparam logic [9:0] EV_S = 10'h200;
  localparam logic [9:0] EV_P = 10'h201;

  logic        inputClock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        dataValid;
  logic [15:0] readValue;
  logic        ackError;
  logic        sda_in;
  logic        sda_oe;
  logic        scl_oe;

  logic        slvDrive;
  logic        sdaBus;
  logic        sclBus;
  logic        slvPresent;
  logic [15:0] slvData;

  int checks  = 0;
  int errors  = 0;
  int dvCount = 0;
  int cyc     = 0;

  assign sdaBus = !(sda_oe || slvDrive);
  assign sclBus = !scl_oe;
  assign sda_in = sdaBus;

  always #5 inputClock = ~inputClock;

  i2c_register_reader #(
    .INPUT_CLOCK_SPEED(CLK_HZ),
    .I2C_SPEED(SCL_HZ),
    .DEVICE_ADDRESS(7'h48),
    .REGISTER_ADDRESS(8'h00)
  ) dut (
    .inputClock(inputClock),
    .reset_n(reset_n),
    .start(start),
    .busy(busy),
    .dataValid(dataValid),
    .readValue(readValue),
    .ackError(ackError),
    .sda_in(sda_in),
    .sda_oe(sda_oe),
    .scl_oe(scl_oe)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural slave: acks its address and data writes, returns slvData MSB first on reads
  logic       sSclPrev, sSdaPrev, sReading, sAddrOk, sIsAddr, sByte, sMAck;
  logic [3:0] sCnt;
  logic [7:0] sRx;
  logic [7:0] sCur;
  assign sCur = sByte ? slvData[7:0] : slvData[15:8];

  always @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      sSclPrev <= 1'b1;
      sSdaPrev <= 1'b1;
      sCnt     <= 4'd0;
      sRx      <= 8'd0;
      sReading <= 1'b0;
      sAddrOk  <= 1'b0;
      sIsAddr  <= 1'b0;
      sByte    <= 1'b0;
      sMAck    <= 1'b0;
      slvDrive <= 1'b0;
    end else begin
      sSclPrev <= sclBus;
      sSdaPrev <= sdaBus;
      if (sclBus && sSclPrev && sSdaPrev && !sdaBus) begin
        sCnt     <= 4'd0;
        sIsAddr  <= 1'b1;
        sReading <= 1'b0;
        slvDrive <= 1'b0;
      end else if (sclBus && sSclPrev && !sSdaPrev && sdaBus) begin
        sCnt     <= 4'd0;
        sIsAddr  <= 1'b0;
        sReading <= 1'b0;
        sAddrOk  <= 1'b0;
        slvDrive <= 1'b0;
      end else if (sclBus && !sSclPrev) begin
        if (sCnt < 4'd8 && !sReading) sRx <= {sRx[6:0], sdaBus};
        if (sCnt == 4'd8 && sReading) sMAck <= !sdaBus;
        sCnt <= sCnt + 4'd1;
      end else if (!sclBus && sSclPrev) begin
        if (sCnt == 4'd8) begin
          if (sReading) slvDrive <= 1'b0;
          else if (sIsAddr) begin
            sAddrOk  <= slvPresent && (sRx[7:1] == 7'h48);
            slvDrive <= slvPresent && (sRx[7:1] == 7'h48);
          end else slvDrive <= sAddrOk;
        end else if (sCnt == 4'd9) begin
          sCnt    <= 4'd0;
          sIsAddr <= 1'b0;
          if (sIsAddr && sAddrOk && sRx[0]) begin
            sReading <= 1'b1;
            sByte    <= 1'b0;
            slvDrive <= !slvData[15];
          end else if (sReading && sMAck) begin
            sByte    <= 1'b1;
            slvDrive <= !slvData[7];
          end else begin
            sReading <= 1'b0;
            slvDrive <= 1'b0;
          end
        end else if (sReading && sCnt >= 4'd1 && sCnt <= 4'd7) begin
          slvDrive <= !sCur[3'(4'd7 - sCnt)];
        end
      end
    end
  end

  // Transaction-level model state and expected bus events
  bit          busyM = 1'b0;
  bit          dvM = 1'b0;
  bit          ackErrM = 1'b0;
  bit          pendGoodM = 1'b0;
  logic [15:0] readM = 16'h0000;
  logic [15:0] pendValM = 16'h0000;
  int          leftM = 0;
  int          totalM = 0;
  logic [9:0]  expQ[$];

  logic        monScl = 1'b1;
  logic        monSda = 1'b1;
  logic [8:0]  monBits = 9'd0;
  int          monCnt = 0;
  bit          havePrevRise = 1'b0;
  int          lastRise = 0;

  task automatic checkEvent(input logic [9:0] ev);
    logic [9:0] expEv;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL busEvent: got %0h, expected no event (t=%0t)", ev, $time);
    end else begin
      expEv = expQ.pop_front();
      checkOutput("busEvent", 32'(ev), 32'(expEv));
    end
  endtask

  // Compare process: DUT outputs against the model and bus traffic against the expected event list, every cycle
  initial begin
    forever begin
      @(negedge inputClock);
      cyc++;
      if (!reset_n) begin
        busyM = 1'b0;
        dvM = 1'b0;
        ackErrM = 1'b0;
        readM = 16'h0000;
        expQ.delete();
        monScl = 1'b1;
        monSda = 1'b1;
        monCnt = 0;
        havePrevRise = 1'b0;
      end
      checkOutput("busy", 32'(busy), 32'(busyM));
      checkOutput("dataValid", 32'(dataValid), 32'(dvM));
      checkOutput("readValue", 32'(readValue), 32'(readM));
      if (!busyM) begin
        checkOutput("ackError", 32'(ackError), 32'(ackErrM));
        checkOutput("sdaIdleReleased", 32'(sda_oe), 0);
        checkOutput("sclIdleReleased", 32'(scl_oe), 0);
        havePrevRise = 1'b0;
      end else if (totalM - leftM < 9 * SLOT) begin
        checkOutput("ackErrorBeforeAck1", 32'(ackError), 0);
      end
      if (dataValid) dvCount++;
      if (reset_n) begin
        if (sclBus && monScl && (sdaBus != monSda)) begin
          monCnt = 0;
          checkEvent(sdaBus ? EV_P : EV_S);
        end else if (sclBus && !monScl) begin
          if (havePrevRise) checkOutput("sclPeriod", 32'(cyc - lastRise), SLOT);
          havePrevRise = 1'b1;
          lastRise = cyc;
          monBits = {monBits[7:0], sdaBus};
          monCnt++;
          if (monCnt == 9) begin
            checkEvent({1'b0, monBits});
            monCnt = 0;
          end
        end
        monScl = sclBus;
        monSda = sdaBus;
        dvM = 1'b0;
        if (busyM) begin
          if (leftM == 1) begin
            busyM = 1'b0;
            if (pendGoodM) begin
              readM = pendValM;
              dvM = 1'b1;
            end else begin
              ackErrM = 1'b1;
            end
          end
          leftM--;
        end else if (start) begin
          busyM = 1'b1;
          ackErrM = 1'b0;
          pendGoodM = slvPresent;
          pendValM = slvData;
          totalM = slvPresent ? GOOD_CYCLES : NACK_CYCLES;
          leftM = totalM;
          expQ.push_back(EV_S);
          if (slvPresent) begin
            expQ.push_back({1'b0, 8'h90, 1'b0});
            expQ.push_back({1'b0, 8'h00, 1'b0});
            expQ.push_back(EV_S);
            expQ.push_back({1'b0, 8'h91, 1'b0});
            expQ.push_back({1'b0, slvData[15:8], 1'b0});
            expQ.push_back({1'b0, slvData[7:0], 1'b1});
          end else begin
            expQ.push_back({1'b0, 8'h90, 1'b1});
          end
          expQ.push_back(EV_P);
        end
      end
    end
  end

  // Configure the slave and pulse start for one clock
  task automatic applyStimulus(input logic present, input logic [15:0] data);
    slvPresent = present;
    slvData = data;
    dvCount = 0;
    @(posedge inputClock);
    #2 start = 1'b1;
    @(posedge inputClock);
    #2 start = 1'b0;
  endtask

  // Directed scenarios with hand-computed expectations
  initial begin
    reset_n = 1'b1;
    start = 1'b0;
    slvPresent = 1'b1;
    slvData = 16'h0000;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge inputClock);
    #1;
    checkOutput("resetBusy", 32'(busy), 0);
    checkOutput("resetDataValid", 32'(dataValid), 0);
    checkOutput("resetReadValue", 32'(readValue), 'h0000);
    checkOutput("resetAckError", 32'(ackError), 0);
    checkOutput("resetSdaOe", 32'(sda_oe), 0);
    checkOutput("resetSclOe", 32'(scl_oe), 0);
    @(posedge inputClock);
    #2 reset_n = 1'b1;
    repeat (5) @(posedge inputClock);

    $display("[TB] good read 0x1234");
    applyStimulus(1'b1, 16'h1234);
    repeat (GOOD_CYCLES + 20) @(posedge inputClock);
    #1;
    checkOutput("case1ReadValue", 32'(readValue), 'h1234);
    checkOutput("case1DataValidPulses", 32'(dvCount), 1);
    checkOutput("case1AckError", 32'(ackError), 0);
    checkOutput("case1EventsLeft", 32'(expQ.size()), 0);

    $display("[TB] absent slave");
    applyStimulus(1'b0, 16'hDEAD);
    repeat (NACK_CYCLES + 20) @(posedge inputClock);
    #1;
    checkOutput("case2AckError", 32'(ackError), 1);
    checkOutput("case2ReadValueHeld", 32'(readValue), 'h1234);
    checkOutput("case2DataValidPulses", 32'(dvCount), 0);
    checkOutput("case2EventsLeft", 32'(expQ.size()), 0);

    $display("[TB] recovery read 0xFF00");
    applyStimulus(1'b1, 16'hFF00);
    repeat (3) @(posedge inputClock);
    #1;
    checkOutput("case3AckErrorCleared", 32'(ackError), 0);
    checkOutput("case3BusyHigh", 32'(busy), 1);
    repeat (GOOD_CYCLES + 20) @(posedge inputClock);
    #1;
    checkOutput("case3ReadValue", 32'(readValue), 'hFF00);
    checkOutput("case3DataValidPulses", 32'(dvCount), 1);
    checkOutput("case3EventsLeft", 32'(expQ.size()), 0);

    $display("[TB] start pulsed while busy");
    applyStimulus(1'b1, 16'hA55A);
    repeat (100) @(posedge inputClock);
    #2 start = 1'b1;
    @(posedge inputClock);
    #2 start = 1'b0;
    repeat (GOOD_CYCLES + 20) @(posedge inputClock);
    #1;
    checkOutput("case4ReadValue", 32'(readValue), 'hA55A);
    checkOutput("case4DataValidPulses", 32'(dvCount), 1);
    checkOutput("case4Busy", 32'(busy), 0);
    checkOutput("case4EventsLeft", 32'(expQ.size()), 0);

    $display("[TB] reset during MSB read");
    applyStimulus(1'b1, 16'h5AA5);
    repeat (32 * SLOT + 15) @(posedge inputClock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("case5SdaOe", 32'(sda_oe), 0);
    checkOutput("case5SclOe", 32'(scl_oe), 0);
    checkOutput("case5Busy", 32'(busy), 0);
    checkOutput("case5ReadValue", 32'(readValue), 'h0000);
    repeat (3) @(posedge inputClock);
    #2 reset_n = 1'b1;
    repeat (5) @(posedge inputClock);
    applyStimulus(1'b1, 16'h0FF0);
    repeat (GOOD_CYCLES + 20) @(posedge inputClock);
    #1;
    checkOutput("case5ReadValueAfter", 32'(readValue), 'h0FF0);
    checkOutput("case5DataValidPulses", 32'(dvCount), 1);
    checkOutput("case5AckError", 32'(ackError), 0);
    checkOutput("case5EventsLeft", 32'(expQ.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
